// File: rtl/beam_mask_cfg_ctrl.sv
// beam_mask_cfg_ctrl
//   Per-beam channel-use / channel-invert mask controller. A register port writes a shadow
//   bank; an apply request arms a commit that copies the whole shadow bank into the active
//   bank on the next frame-boundary sync. After every commit (and after reset) trig_valid_o
//   is held low for FLUSH_CYCLES cycles so downstream never acts on mixed-config squares.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   wr_i, addr_i, wdata_i shadow write: wdata_i = {invert, use}
//   rd_i, rsel_i          read strobe, bank select (0 shadow, 1 active)
//   rdata_o, rvalid_o     registered read data and one-cycle valid
//   apply_i, sync_i       commit request, frame-boundary commit point
//   busy_o                high while armed or flushing
//   update_o              one-cycle pulse after the active bank changes
//   trig_valid_o          downstream may use beam squares
//   beam_use_o            active use masks, beam b at [NCHAN*b +: NCHAN]
//   beam_invert_o         active invert masks, same packing
module beam_mask_cfg_ctrl #(
  parameter int unsigned NBEAMS       = 48,
  parameter int unsigned NCHAN        = 8,
  parameter int unsigned FLUSH_CYCLES = 6,
  localparam int unsigned ABITS       = $clog2(NBEAMS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_i,
  input  logic [ABITS-1:0]        addr_i,
  input  logic [2*NCHAN-1:0]      wdata_i,
  input  logic                    rd_i,
  input  logic                    rsel_i,
  output logic [2*NCHAN-1:0]      rdata_o,
  output logic                    rvalid_o,
  input  logic                    apply_i,
  input  logic                    sync_i,
  output logic                    busy_o,
  output logic                    update_o,
  output logic                    trig_valid_o,
  output logic [NBEAMS*NCHAN-1:0] beam_use_o,
  output logic [NBEAMS*NCHAN-1:0] beam_invert_o
);

  localparam logic [7:0] FlushLoad = 8'(FLUSH_CYCLES);

  typedef enum logic [1:0] {StIdle, StArmed, StFlush} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             rearm_q, rearm_d;
  logic             commit;

  logic [NCHAN-1:0] shadow_use_q [NBEAMS];
  logic [NCHAN-1:0] shadow_inv_q [NBEAMS];
  logic [NCHAN-1:0] active_use_q [NBEAMS];
  logic [NCHAN-1:0] active_inv_q [NBEAMS];

  logic [2*NCHAN-1:0] rdata_q, rdata_d;
  logic               rvalid_q, update_q, trig_q, busy_q;
  logic               addr_ok;

  assign addr_ok = (32'(addr_i) < NBEAMS);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rearm_d = rearm_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A sync in the same cycle as apply is deliberately not a commit point.
        if (apply_i) state_d = StArmed;
      end
      StArmed: begin
        if (sync_i) begin
          commit  = 1'b1;
          cnt_d   = FlushLoad;
          state_d = StFlush;
        end
      end
      StFlush: begin
        cnt_d = cnt_q - 8'd1;
        if (apply_i) rearm_d = 1'b1;
        if (cnt_d == 8'd0) begin
          // An apply on the final flush cycle still counts as a pending rearm.
          state_d = (rearm_q || apply_i) ? StArmed : StIdle;
          rearm_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    rdata_d = '0;
    if (addr_ok) begin
      if (rsel_i) rdata_d = {active_inv_q[addr_i], active_use_q[addr_i]};
      else        rdata_d = {shadow_inv_q[addr_i], shadow_use_q[addr_i]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < int'(NBEAMS); b++) begin
        shadow_use_q[b] <= '1;
        shadow_inv_q[b] <= '0;
        active_use_q[b] <= '1;
        active_inv_q[b] <= '0;
      end
      state_q  <= StFlush;
      cnt_q    <= FlushLoad;
      rearm_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      update_q <= 1'b0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rearm_q <= rearm_d;
      // Non-blocking copy: a write on the commit edge lands in shadow only and the
      // active bank takes the pre-write shadow contents.
      if (commit) begin
        active_use_q <= shadow_use_q;
        active_inv_q <= shadow_inv_q;
      end
      if (wr_i && addr_ok) begin
        shadow_use_q[addr_i] <= wdata_i[NCHAN-1:0];
        shadow_inv_q[addr_i] <= wdata_i[2*NCHAN-1:NCHAN];
      end
      if (rd_i) rdata_q <= rdata_d;
      rvalid_q <= rd_i;
      update_q <= commit;
      trig_q   <= (state_d != StFlush);
      busy_q   <= (state_d != StIdle);
    end
  end

  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign update_o     = update_q;
  assign trig_valid_o = trig_q;
  assign busy_o       = busy_q;

  for (genvar b = 0; b < int'(NBEAMS); b++) begin : g_flat
    assign beam_use_o[NCHAN*b +: NCHAN]    = active_use_q[b];
    assign beam_invert_o[NCHAN*b +: NCHAN] = active_inv_q[b];
  end

endmodule

// File: tb/tb_beam_mask_cfg_ctrl.sv
// Self-checking bench for beam_mask_cfg_ctrl. A reference model of the shadow and active
// banks produces expected read data and expected committed masks; these are queued when
// stimulus is driven and compared when rvalid_o / update_o are observed.
module tb_beam_mask_cfg_ctrl;
  localparam int NBEAMS = 48;
  localparam int NCHAN  = 8;
  localparam int FLUSH  = 6;
  localparam int ABITS  = $clog2(NBEAMS);

  logic                    clk = 1'b0;
  logic                    rst_i, wr_i, rd_i, rsel_i, apply_i, sync_i;
  logic [ABITS-1:0]        addr_i;
  logic [2*NCHAN-1:0]      wdata_i, rdata_o;
  logic                    rvalid_o, busy_o, update_o, trig_valid_o;
  logic [NBEAMS*NCHAN-1:0] beam_use_o, beam_invert_o;

  beam_mask_cfg_ctrl #(
    .NBEAMS(NBEAMS), .NCHAN(NCHAN), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rd_i(rd_i), .rsel_i(rsel_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .apply_i(apply_i), .sync_i(sync_i), .busy_o(busy_o), .update_o(update_o),
    .trig_valid_o(trig_valid_o), .beam_use_o(beam_use_o), .beam_invert_o(beam_invert_o)
  );

  always #5 clk = ~clk;

  logic [NCHAN-1:0] m_sh_use [NBEAMS];
  logic [NCHAN-1:0] m_sh_inv [NBEAMS];
  logic [NCHAN-1:0] m_ac_use [NBEAMS];
  logic [NCHAN-1:0] m_ac_inv [NBEAMS];

  logic [2*NCHAN-1:0]      rd_q [$];
  logic [NBEAMS*NCHAN-1:0] cu_q [$];
  logic [NBEAMS*NCHAN-1:0] ci_q [$];

  int checks   = 0;
  int failures = 0;
  int updates_seen = 0;

  function automatic logic [NBEAMS*NCHAN-1:0] flat_use();
    logic [NBEAMS*NCHAN-1:0] v;
    for (int b = 0; b < NBEAMS; b++) v[NCHAN*b +: NCHAN] = m_ac_use[b];
    return v;
  endfunction

  function automatic logic [NBEAMS*NCHAN-1:0] flat_inv();
    logic [NBEAMS*NCHAN-1:0] v;
    for (int b = 0; b < NBEAMS; b++) v[NCHAN*b +: NCHAN] = m_ac_inv[b];
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NBEAMS; b++) begin
      m_sh_use[b] = '1; m_sh_inv[b] = '0;
      m_ac_use[b] = '1; m_ac_inv[b] = '0;
    end
    rd_q.delete(); cu_q.delete(); ci_q.delete();
  endtask

  // One clock of stimulus, driven just after a falling edge; returns at the next falling edge.
  task automatic cyc(input logic wr, input int addr, input logic [2*NCHAN-1:0] wd,
                     input logic rd, input logic rsel, input logic apply, input logic sync,
                     input logic exp_commit);
    wr_i = wr; addr_i = addr[ABITS-1:0]; wdata_i = wd;
    rd_i = rd; rsel_i = rsel; apply_i = apply; sync_i = sync;
    if (rd) begin
      if (addr >= NBEAMS)  rd_q.push_back('0);
      else if (rsel)       rd_q.push_back({m_ac_inv[addr], m_ac_use[addr]});
      else                 rd_q.push_back({m_sh_inv[addr], m_sh_use[addr]});
    end
    if (exp_commit) begin
      m_ac_use = m_sh_use;
      m_ac_inv = m_sh_inv;
      cu_q.push_back(flat_use());
      ci_q.push_back(flat_inv());
    end
    if (wr && addr < NBEAMS) begin
      m_sh_use[addr] = wd[NCHAN-1:0];
      m_sh_inv[addr] = wd[2*NCHAN-1:NCHAN];
    end
    @(negedge clk);
    wr_i = 0; rd_i = 0; rsel_i = 0; apply_i = 0; sync_i = 0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  // Counts consecutive cycles with trig_valid_o low, bounded.
  task automatic count_low(output int n);
    n = 0;
    while (trig_valid_o !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Scoreboard side: compare queued expectations whenever the DUT presents output.
  always @(negedge clk) begin
    if (rvalid_o === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rvalid_unexpected: rdata=%h with no read outstanding", rdata_o);
      end else begin
        logic [2*NCHAN-1:0] e;
        e = rd_q.pop_front();
        if (rdata_o !== e) begin
          failures++;
          $display("FAIL read_data: got %h expected %h", rdata_o, e);
        end
      end
    end
    if (update_o === 1'b1) begin
      updates_seen++;
      checks++;
      if (cu_q.size() == 0) begin
        failures++;
        $display("FAIL update_unexpected: update_o pulsed with no commit expected");
      end else begin
        logic [NBEAMS*NCHAN-1:0] eu, ei;
        eu = cu_q.pop_front();
        ei = ci_q.pop_front();
        if (beam_use_o !== eu || beam_invert_o !== ei) begin
          failures++;
          $display("FAIL commit_masks: use=%h inv=%h expected use=%h inv=%h",
                   beam_use_o, beam_invert_o, eu, ei);
        end
      end
    end
  end

  task automatic test_reset();
    int n;
    @(negedge clk); rst_i = 1;
    @(negedge clk); @(negedge clk);
    rst_i = 0;
    model_reset();
    updates_seen = 0;
    checks++;
    if (rdata_o !== '0 || rvalid_o !== 0 || update_o !== 0) begin
      failures++;
      $display("FAIL reset_rd: rdata=%h rvalid=%b update=%b expected 0/0/0",
               rdata_o, rvalid_o, update_o);
    end
    checks++;
    if (trig_valid_o !== 0 || busy_o !== 1) begin
      failures++;
      $display("FAIL reset_flags: trig=%b busy=%b expected 0/1", trig_valid_o, busy_o);
    end
    checks++;
    if (beam_use_o !== {NBEAMS*NCHAN{1'b1}} || beam_invert_o !== '0) begin
      failures++;
      $display("FAIL reset_masks: use=%h inv=%h", beam_use_o, beam_invert_o);
    end
    count_low(n);
    checks++;
    if (n != FLUSH) begin
      failures++;
      $display("FAIL reset_flush_len: got %0d expected %0d", n, FLUSH);
    end
    checks++;
    if (busy_o !== 0) begin
      failures++;
      $display("FAIL reset_busy_fall: busy=%b expected 0", busy_o);
    end
    idle(2);
    checks++;
    if (updates_seen != 0) begin
      failures++;
      $display("FAIL reset_no_update: saw %0d update pulses expected 0", updates_seen);
    end
  endtask

  task automatic test_reads();
    cyc(1, 5, 16'h0F3C, 0, 0, 0, 0, 0);
    cyc(0, 5, '0, 1, 0, 0, 0, 0);              // shadow -> 0F3C
    cyc(0, 5, '0, 1, 1, 0, 0, 0);              // active -> 00FF
    cyc(0, 50, '0, 1, 0, 0, 0, 0);             // out of range -> 0
    cyc(1, 50, 16'hFFFF, 0, 0, 0, 0, 0);       // ignored write
    cyc(1, 5, 16'hAAAA, 1, 0, 0, 0, 0);        // same-cycle read sees old value
    cyc(1, 5, 16'h0F3C, 1, 0, 0, 0, 0);        // back-to-back, sees AAAA
    idle(1);
    checks++;
    if (rvalid_o !== 0) begin
      failures++;
      $display("FAIL rvalid_pulse: rvalid=%b expected 0 after reads end", rvalid_o);
    end
  endtask

  task automatic test_write_commit();
    int n;
    cyc(1, 5, 16'h0F3C, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 1, 0, 0);
    checks++;
    if (busy_o !== 1 || trig_valid_o !== 1) begin
      failures++;
      $display("FAIL armed_flags: busy=%b trig=%b expected 1/1", busy_o, trig_valid_o);
    end
    idle(9);
    cyc(0, 0, '0, 0, 0, 0, 1, 1);
    checks++;
    if (beam_use_o[47:40] !== 8'h3C || beam_invert_o[47:40] !== 8'h0F || update_o !== 1) begin
      failures++;
      $display("FAIL commit_beam5: use=%h inv=%h update=%b expected 3c/0f/1",
               beam_use_o[47:40], beam_invert_o[47:40], update_o);
    end
    count_low(n);
    checks++;
    if (n != FLUSH) begin
      failures++;
      $display("FAIL commit_flush_len: got %0d expected %0d", n, FLUSH);
    end
  endtask

  task automatic test_apply_sync_same();
    int n;
    cyc(1, 7, 16'h1234, 0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 1, 1, 0);
    checks++;
    if (update_o !== 0 || busy_o !== 1 || beam_use_o[63:56] !== 8'hFF) begin
      failures++;
      $display("FAIL same_cycle_no_commit: update=%b busy=%b use7=%h expected 0/1/ff",
               update_o, busy_o, beam_use_o[63:56]);
    end
    idle(3);
    cyc(0, 0, '0, 0, 0, 0, 1, 1);
    count_low(n);
    checks++;
    if (n != FLUSH) begin
      failures++;
      $display("FAIL same_cycle_flush_len: got %0d expected %0d", n, FLUSH);
    end
  endtask

  task automatic test_rearm();
    int n;
    cyc(1, 10, 16'h00A5, 0, 0, 1, 0, 0);
    cyc(0, 0, '0, 0, 0, 0, 1, 1);
    cyc(1, 10, 16'h3C5A, 0, 0, 1, 0, 0);       // apply during flush
    count_low(n);
    checks++;
    if (n != FLUSH - 1) begin
      failures++;
      $display("FAIL rearm_flush_len: got %0d expected %0d", n, FLUSH - 1);
    end
    checks++;
    if (busy_o !== 1) begin
      failures++;
      $display("FAIL rearm_armed: busy=%b expected 1", busy_o);
    end
    idle(2);
    cyc(0, 0, '0, 0, 0, 0, 1, 1);
    checks++;
    if (beam_use_o[87:80] !== 8'h5A || beam_invert_o[87:80] !== 8'h3C) begin
      failures++;
      $display("FAIL rearm_commit: use=%h inv=%h expected 5a/3c",
               beam_use_o[87:80], beam_invert_o[87:80]);
    end
    count_low(n);
  endtask

  task automatic test_commit_write_race();
    int n;
    cyc(0, 0, '0, 0, 0, 1, 0, 0);
    cyc(1, 2, 16'h5A5A, 0, 0, 0, 1, 1);
    checks++;
    if (beam_use_o[23:16] !== 8'hFF || beam_invert_o[23:16] !== 8'h00) begin
      failures++;
      $display("FAIL race_active_beam2: use=%h inv=%h expected ff/00",
               beam_use_o[23:16], beam_invert_o[23:16]);
    end
    cyc(0, 2, '0, 1, 0, 0, 0, 0);              // shadow -> 5A5A
    cyc(0, 2, '0, 1, 1, 0, 0, 0);              // active -> 00FF
    count_low(n);
  endtask

  task automatic test_reset_armed();
    int n;
    cyc(1, 3, 16'h1111, 0, 0, 1, 0, 0);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    model_reset();
    checks++;
    if (beam_use_o !== {NBEAMS*NCHAN{1'b1}} || beam_invert_o !== '0 || busy_o !== 1) begin
      failures++;
      $display("FAIL reset_armed_masks: use=%h inv=%h busy=%b", beam_use_o, beam_invert_o,
               busy_o);
    end
    count_low(n);
    checks++;
    if (n != FLUSH) begin
      failures++;
      $display("FAIL reset_armed_flush_len: got %0d expected %0d", n, FLUSH);
    end
    cyc(0, 0, '0, 0, 0, 0, 1, 0);
    checks++;
    if (update_o !== 0 || busy_o !== 0 || beam_use_o[31:24] !== 8'hFF) begin
      failures++;
      $display("FAIL reset_armed_no_commit: update=%b busy=%b use3=%h expected 0/0/ff",
               update_o, busy_o, beam_use_o[31:24]);
    end
    cyc(0, 3, '0, 1, 0, 0, 0, 0);              // shadow beam 3 back to 00FF
    idle(2);
  endtask

  initial begin
    rst_i = 1; wr_i = 0; rd_i = 0; rsel_i = 0; apply_i = 0; sync_i = 0;
    addr_i = '0; wdata_i = '0;
    model_reset();
    test_reset();
    test_reads();
    test_write_commit();
    test_apply_sync_same();
    test_rearm();
    test_commit_write_race();
    test_reset_armed();
    checks++;
    if (rd_q.size() != 0 || cu_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: reads left %0d commits left %0d expected 0/0",
               rd_q.size(), cu_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beam_mask_cfg_ctrl.md
Name: beam_mask_cfg_ctrl

Overview:
- Configuration controller for the low-amplitude beamform array. Holds per-beam channel-use and channel-invert masks in a shadow bank written by a register interface.
- Commits the shadow bank to the active bank atomically on a frame-boundary sync after an apply request.
- After each commit, blanks a trigger-valid flag for a fixed flush window so that squares computed from mixed configurations are never acted on.

Parameters:
- NBEAMS, 48, number of beams configured.
- NCHAN, 8, channels per beam (width of each use/invert mask).
- FLUSH_CYCLES, 6, cycles trig_valid_o stays low after a commit or reset (covers beamform + square + correction latency); legal range 1..255.
- ABITS, $clog2(NBEAMS), beam address width (localparam).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- wr_i  in  1  shadow write strobe.
- addr_i  in  ABITS  beam index for write/read.
- wdata_i  in  2*NCHAN  {invert[NCHAN-1:0], use[NCHAN-1:0]}.
- rd_i  in  1  read strobe.
- rsel_i  in  1  read bank select: 0 = shadow, 1 = active.
- rdata_o  out  2*NCHAN  read data, same packing as wdata_i.
- rvalid_o  out  1  read data valid pulse.
- apply_i  in  1  commit request pulse.
- sync_i  in  1  frame-boundary pulse; commits happen only here.
- busy_o  out  1  high while ARMED or FLUSH.
- update_o  out  1  one-cycle pulse on the cycle after the active bank changes.
- trig_valid_o  out  1  downstream may use beam squares.
- beam_use_o  out  NBEAMS*NCHAN  active use masks; beam b at [NCHAN*b +: NCHAN].
- beam_invert_o  out  NBEAMS*NCHAN  active invert masks, same packing.

Behaviour:
- Reset, rst_i=1 for one clk_i edge:
  - shadow and active use = all 1s, invert = all 0s;
  - rdata_o = 0, rvalid_o = 0, update_o = 0;
  - state = FLUSH with counter = FLUSH_CYCLES;
  - trig_valid_o = 0, busy_o = 1, pending-rearm flag cleared.
  - A reset mid-operation discards any ARMED or pending apply.
- Writes:
  - wr_i with addr_i < NBEAMS updates shadow[addr_i] at the clock edge, in any state.
  - addr_i >= NBEAMS: write ignored.
  - Writes never touch the active bank directly.
- Reads:
  - rd_i registers rdata_o = selected bank[addr_i] with rvalid_o = 1 one cycle later. Out-of-range address returns 0 with rvalid_o = 1.
  - A read and a write to the same shadow address in the same cycle return the old value.
- FSM states:
  - IDLE:
    - apply_i -> ARMED. A sync_i in the same cycle does NOT commit.
  - ARMED:
    - sync_i -> copy the entire shadow bank to active at that edge, load counter = FLUSH_CYCLES, -> FLUSH.
    - apply_i in ARMED is ignored.
    - A wr_i on the commit cycle lands in shadow only; the commit takes pre-write shadow contents.
  - FLUSH:
    - Counter decrements each cycle; at 0 -> IDLE, or -> ARMED if the pending-rearm flag is set (flag then clears).
    - apply_i during FLUSH sets the pending-rearm flag.
    - sync_i during FLUSH is ignored.
- update_o: registered, high exactly one cycle, on the cycle following each commit edge (not on reset).
- trig_valid_o:
  - registered; 0 in FLUSH, 1 in IDLE/ARMED;
  - goes low the cycle after the commit edge and stays low for exactly FLUSH_CYCLES cycles.
- busy_o = (state != IDLE), registered.
- beam_use_o / beam_invert_o: driven directly from active registers; change only on a commit edge or reset.

Test Plan:
- Reset release → all beam_use_o = 1s, beam_invert_o = 0; trig_valid_o low for 6 cycles then high; busy_o falls with it; update_o never pulses.
- Write beam 5 = 0x0F3C, apply_i, sync_i 10 cycles later → beam_use_o[47:40] = 0x3C, beam_invert_o[47:40] = 0x0F one cycle after the sync edge; update_o pulse; trig_valid_o low 6 cycles.
- Write beam 5 = 0x0F3C, rd_i rsel_i=0 and rsel_i=1 before commit → 0x0F3C and 0x00FF respectively, each with rvalid_o one cycle later; addr 50 read → 0 with rvalid_o = 1.
- apply_i and sync_i in the same IDLE cycle → no commit; the next sync_i commits.
- apply_i during FLUSH → on flush end state goes ARMED (busy_o stays high); next sync_i commits the second set.
- wr_i beam 2 on the sync_i commit edge → active beam 2 keeps its old value, shadow holds the new value; rst_i asserted while ARMED → no commit on later sync_i, masks return to reset values.
